// File: rtl/factocore_pkg.sv
// Shared definitions for the factorial core: register map, FSM states and
// opdone status encodings.
package factocore_pkg;

  localparam logic [15:0] ADDR_OPSTART  = 16'h7000;
  localparam logic [15:0] ADDR_OPCLEAR  = 16'h7008;
  localparam logic [15:0] ADDR_OPDONE   = 16'h7010;
  localparam logic [15:0] ADDR_INTREN   = 16'h7018;
  localparam logic [15:0] ADDR_OPERAND  = 16'h7020;
  localparam logic [15:0] ADDR_RESULT_H = 16'h7028;
  localparam logic [15:0] ADDR_RESULT_L = 16'h7030;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OPDONE_IDLE = 2'b00;
  localparam logic [1:0] OPDONE_MULT = 2'b10;
  localparam logic [1:0] OPDONE_DONE = 2'b11;

  // Status code reported through the opdone register for a given FSM state.
  function automatic logic [1:0] opdone_code(input state_t s);
    case (s)
      ST_MULT: return OPDONE_MULT;
      ST_DONE: return OPDONE_DONE;
      default: return OPDONE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/facto_mul.sv
// Iterative 128x64 multiplier, radix-16: one load cycle on start, then 16
// shift-add cycles each consuming 4 multiplier bits. The product is kept
// modulo 2^128. done pulses for one cycle once the product is valid, and a
// new start always restarts the unit, even mid-operation.
module facto_mul (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [127:0] multiplicand,
  input  logic [63:0]  multiplier,
  output logic [127:0] product,
  output logic         done
);

  logic [127:0] mcand_sh;
  logic [127:0] acc;
  logic [63:0]  mplier_sh;
  logic [3:0]   digit_cnt;
  logic         busy;

  // Partial product of the shifted multiplicand and one radix-16 digit,
  // truncated to 128 bits.
  function automatic logic [127:0] digit_pp(input logic [127:0] m,
                                            input logic [3:0]   d);
    logic [127:0] dx;
    dx = {124'd0, d};
    return m * dx;
  endfunction

  // Sequencing: busy flag, digit counter and the one-cycle done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      digit_cnt <= 4'd0;
    end else if (start) begin
      busy      <= 1'b1;
      done      <= 1'b0;
      digit_cnt <= 4'd0;
    end else if (busy) begin
      digit_cnt <= digit_cnt + 4'd1;
      if (digit_cnt == 4'd15) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

  // Datapath: LSB-first digit accumulation with the multiplicand shifted up
  // by one digit per cycle.
  always_ff @(posedge clk) begin
    if (start) begin
      mcand_sh  <= multiplicand;
      mplier_sh <= multiplier;
      acc       <= 128'd0;
    end else if (busy) begin
      acc       <= acc + digit_pp(mcand_sh, mplier_sh[3:0]);
      mcand_sh  <= mcand_sh << 4;
      mplier_sh <= mplier_sh >> 4;
    end
  end

  assign product = acc;

endmodule

// File: rtl/facto_core.sv
// Memory-mapped factorial engine. Computes operand! modulo 2^128 by repeated
// 17-cycle multiply steps in facto_mul. The first edge that sees opstart set
// in IDLE either finishes immediately (operand <= 1) or enters MULT; DONE is
// reached 17*(operand-1) edges after that one.
// Build option: FACTOCORE_INTR_EN enables the intrEn register and interrupt
// output; without it interrupt is 0 and intrEn reads 0.
module facto_core
  import factocore_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s_sel,
  input  logic        s_wr,
  input  logic [15:0] s_addr,
  input  logic [63:0] s_din,
  output logic [63:0] s_dout,
  output logic        interrupt
);

  state_t       state;
  logic         opstart;
  logic         opclear;
  logic         intr_en;
  logic [63:0]  operand;
  logic [63:0]  counter;
  logic [127:0] result;
  logic [1:0]   opdone;
  logic         wr_en;

  logic         mul_start;
  logic         mul_done;
  logic [127:0] mul_mcand;
  logic [127:0] mul_product;
  logic [63:0]  mul_mplier;

  assign wr_en  = s_sel & s_wr;
  assign opdone = opdone_code(state);

  // Kick a multiply step when leaving IDLE for MULT, and again after every
  // completed step that is not the final one (counter == 2).
  assign mul_start = !opclear &&
                     (((state == ST_IDLE) && opstart && (operand >= 64'd2)) ||
                      ((state == ST_MULT) && mul_done && (counter != 64'd2)));
  assign mul_mcand  = (state == ST_IDLE) ? 128'd1 : mul_product;
  assign mul_mplier = (state == ST_IDLE) ? operand : (counter - 64'd1);

  facto_mul u_mul (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (mul_start),
    .multiplicand (mul_mcand),
    .multiplier   (mul_mplier),
    .product      (mul_product),
    .done         (mul_done)
  );

  // Register writes and the IDLE/MULT/DONE sequencer; opclear overrides both.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      opstart <= 1'b0;
      opclear <= 1'b0;
      operand <= 64'd0;
      counter <= 64'd0;
      result  <= 128'd0;
    end else begin
      if (wr_en) begin
        case (s_addr)
          ADDR_OPSTART: opstart <= s_din[0];
          ADDR_OPCLEAR: opclear <= s_din[0];
          ADDR_OPERAND: if (state != ST_MULT) operand <= s_din;
          default: ;
        endcase
      end

      if (opclear) begin
        state   <= ST_IDLE;
        opstart <= 1'b0;
        result  <= 128'd0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (opstart) begin
              result <= 128'd1;
              if (operand <= 64'd1) begin
                state <= ST_DONE;
              end else begin
                state   <= ST_MULT;
                counter <= operand;
              end
            end
          end
          ST_MULT: begin
            if (mul_done) begin
              result <= mul_product;
              if (counter == 64'd2) state <= ST_DONE;
              else counter <= counter - 64'd1;
            end
          end
          ST_DONE: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef FACTOCORE_INTR_EN
  // Interrupt enable bit; survives opclear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) intr_en <= 1'b0;
    else if (wr_en && (s_addr == ADDR_INTREN)) intr_en <= s_din[0];
  end
`else
  assign intr_en = 1'b0;
`endif

  assign interrupt = intr_en & (state == ST_DONE);

  // Combinational register read-back, zero when no read is in progress.
  always_comb begin
    s_dout = 64'd0;
    if (s_sel && !s_wr) begin
      case (s_addr)
        ADDR_OPSTART:  s_dout = {63'd0, opstart};
        ADDR_OPCLEAR:  s_dout = {63'd0, opclear};
        ADDR_OPDONE:   s_dout = {62'd0, opdone};
        ADDR_INTREN:   s_dout = {63'd0, intr_en};
        ADDR_OPERAND:  s_dout = operand;
        ADDR_RESULT_H: s_dout = result[127:64];
        ADDR_RESULT_L: s_dout = result[63:0];
        default:       s_dout = 64'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_facto_core.sv
// Directed bench for facto_core: register map, factorial results and timing,
// opclear/reset aborts and wrap-around of large factorials.
module tb_facto_core;

  localparam logic [15:0] A_START = 16'h7000;
  localparam logic [15:0] A_CLEAR = 16'h7008;
  localparam logic [15:0] A_DONE  = 16'h7010;
  localparam logic [15:0] A_IEN   = 16'h7018;
  localparam logic [15:0] A_OPER  = 16'h7020;
  localparam logic [15:0] A_RESH  = 16'h7028;
  localparam logic [15:0] A_RESL  = 16'h7030;

`ifdef FACTOCORE_INTR_EN
  localparam bit INTR = 1'b1;
`else
  localparam bit INTR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        s_sel;
  logic        s_wr;
  logic [15:0] s_addr;
  logic [63:0] s_din;
  logic [63:0] s_dout;
  logic        interrupt;

  int total = 0;
  int bad   = 0;

  facto_core dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_sel     (s_sel),
    .s_wr      (s_wr),
    .s_addr    (s_addr),
    .s_din     (s_din),
    .s_dout    (s_dout),
    .interrupt (interrupt)
  );

  always #5 clk = ~clk;

  // Independent reference: n! modulo 2^128.
  function automatic logic [127:0] fact_mod(input int n);
    logic [127:0] m;
    m = 128'd1;
    for (int i = 2; i <= n; i++) m = m * 128'(i);
    return m;
  endfunction

  // Write lands on the posedge; returns 1ns after it.
  task automatic bus_write(input logic [15:0] a, input logic [63:0] d);
    @(negedge clk);
    s_sel = 1'b1; s_wr = 1'b1; s_addr = a; s_din = d;
    @(posedge clk);
    #1;
    s_sel = 1'b0; s_wr = 1'b0; s_din = 64'd0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [63:0] d);
    s_sel = 1'b1; s_wr = 1'b0; s_addr = a;
    #1;
    d = s_dout;
    s_sel = 1'b0;
  endtask

  // Polls opdone once per edge; cyc is the edge index (counting from the
  // opstart write edge as 0) at which DONE is first seen, or -1 on timeout.
  task automatic poll_done(input int base, input int limit, output int cyc,
                           output bit mult_ok, output bit irq_early,
                           output logic irq_done);
    logic [63:0] v;
    cyc = -1; mult_ok = 1'b1; irq_early = 1'b0; irq_done = 1'b0;
    for (int k = base + 1; k <= limit; k++) begin
      @(posedge clk);
      #1;
      bus_read(A_DONE, v);
      if (v == 64'd3) begin
        cyc = k;
        irq_done = interrupt;
        break;
      end
      if (v != 64'd2) mult_ok = 1'b0;
      if (interrupt) irq_early = 1'b1;
    end
  endtask

  task automatic test_reset;
    logic [15:0] addrs [7];
    logic [63:0] v;
    addrs = '{A_START, A_CLEAR, A_DONE, A_IEN, A_OPER, A_RESH, A_RESL};
    for (int i = 0; i < 7; i++) begin
      bus_read(addrs[i], v);
      total++;
      if (v !== 64'd0) begin
        bad++;
        $display("FAIL reset_reg_%0h: got=%0h want=0", addrs[i], v);
      end
    end
    total++;
    if (interrupt !== 1'b0) begin
      bad++;
      $display("FAIL reset_irq: got=%0b want=0", interrupt);
    end
  endtask

  task automatic test_unmapped;
    logic [15:0] addrs [7];
    logic [63:0] v;
    addrs = '{A_START, A_CLEAR, A_DONE, A_IEN, A_OPER, A_RESH, A_RESL};
    bus_write(16'h70FF, 64'd1);
    bus_write(A_RESL, 64'h55);
    bus_write(A_DONE, 64'h3);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) begin
      bus_read(addrs[i], v);
      total++;
      if (v !== 64'd0) begin
        bad++;
        $display("FAIL unmapped_reg_%0h: got=%0h want=0", addrs[i], v);
      end
    end
    bus_read(16'h70FF, v);
    total++;
    if (v !== 64'd0) begin
      bad++;
      $display("FAIL unmapped_read: got=%0h want=0", v);
    end
  endtask

  task automatic test_fact5;
    int cyc; bit mok, early; logic irq;
    logic [63:0] v;
    bus_write(A_IEN, 64'd1);
    bus_write(A_OPER, 64'd5);
    bus_write(A_START, 64'd1);
    poll_done(0, 200, cyc, mok, early, irq);
    total++;
    if (cyc != 69) begin bad++; $display("FAIL f5_latency: got=%0d want=69", cyc); end
    total++;
    if (!mok || early) begin bad++; $display("FAIL f5_mult_phase: mult_ok=%0b irq_early=%0b want 1/0", mok, early); end
    total++;
    if (irq !== INTR) begin bad++; $display("FAIL f5_irq: got=%0b want=%0b", irq, INTR); end
    bus_read(A_RESL, v);
    total++;
    if (v !== 64'd120) begin bad++; $display("FAIL f5_result_l: got=%0d want=120", v); end
    bus_read(A_RESH, v);
    total++;
    if (v !== 64'd0) begin bad++; $display("FAIL f5_result_h: got=%0h want=0", v); end
    bus_read(A_IEN, v);
    total++;
    if (v !== 64'(INTR)) begin bad++; $display("FAIL f5_intren: got=%0h want=%0h", v, INTR); end
    // a further start in DONE must not restart
    bus_write(A_START, 64'd1);
    repeat (20) @(posedge clk);
    #1;
    bus_read(A_DONE, v);
    total++;
    if (v !== 64'd3) begin bad++; $display("FAIL f5_hold_done: got=%0h want=3", v); end
    bus_read(A_RESL, v);
    total++;
    if (v !== 64'd120) begin bad++; $display("FAIL f5_hold_result: got=%0d want=120", v); end
    s_addr = A_OPER; s_sel = 1'b0; s_wr = 1'b0;
    #1;
    total++;
    if (s_dout !== 64'd0) begin bad++; $display("FAIL idle_bus_dout: got=%0h want=0", s_dout); end
  endtask

  task automatic test_fact10;
    int cyc; bit mok, early; logic irq;
    logic [63:0] v;
    bus_write(A_CLEAR, 64'd1);
    bus_write(A_CLEAR, 64'd0);
    bus_read(A_RESL, v);
    total++;
    if (v !== 64'd0) begin bad++; $display("FAIL clr_result_l: got=%0h want=0", v); end
    bus_read(A_OPER, v);
    total++;
    if (v !== 64'd5) begin bad++; $display("FAIL clr_keeps_operand: got=%0h want=5", v); end
    bus_read(A_IEN, v);
    total++;
    if (v !== 64'(INTR)) begin bad++; $display("FAIL clr_keeps_intren: got=%0h want=%0h", v, INTR); end
    bus_read(A_START, v);
    total++;
    if (v !== 64'd0) begin bad++; $display("FAIL clr_opstart: got=%0h want=0", v); end
    bus_write(A_OPER, 64'd10);
    bus_write(A_START, 64'd1);
    poll_done(0, 400, cyc, mok, early, irq);
    total++;
    if (cyc != 154 || !mok) begin bad++; $display("FAIL f10_latency: got=%0d mult_ok=%0b want=154/1", cyc, mok); end
    total++;
    if (irq !== INTR || early) begin bad++; $display("FAIL f10_irq: got=%0b early=%0b want=%0b", irq, early, INTR); end
    bus_read(A_RESL, v);
    total++;
    if (v !== 64'd3628800) begin bad++; $display("FAIL f10_result_l: got=%0d want=3628800", v); end
    bus_read(A_RESH, v);
    total++;
    if (v !== 64'd0) begin bad++; $display("FAIL f10_result_h: got=%0h want=0", v); end
  endtask

  task automatic test_fact68_wrap;
    int cyc; bit mok, early; logic irq;
    logic [63:0] v;
    logic [127:0] exp;
    exp = fact_mod(68);
    bus_write(A_CLEAR, 64'd1);
    bus_write(A_CLEAR, 64'd0);
    bus_write(A_OPER, 64'd68);
    bus_write(A_START, 64'd1);
    repeat (50) @(posedge clk);
    #1;
    bus_read(A_DONE, v);
    total++;
    if (v !== 64'd2) begin bad++; $display("FAIL f68_mid_opdone: got=%0h want=2", v); end
    bus_write(A_OPER, 64'd3);
    bus_read(A_OPER, v);
    total++;
    if (v !== 64'd68) begin bad++; $display("FAIL f68_operand_locked: got=%0d want=68", v); end
    poll_done(51, 3000, cyc, mok, early, irq);
    total++;
    if (cyc != 1140 || !mok) begin bad++; $display("FAIL f68_latency: got=%0d mult_ok=%0b want=1140/1", cyc, mok); end
    bus_read(A_RESL, v);
    total++;
    if (v !== exp[63:0]) begin bad++; $display("FAIL f68_result_l: got=%0h want=%0h", v, exp[63:0]); end
    bus_read(A_RESH, v);
    total++;
    if (v !== exp[127:64]) begin bad++; $display("FAIL f68_result_h: got=%0h want=%0h", v, exp[127:64]); end
  endtask

  task automatic test_small_operands;
    int cyc; bit mok, early; logic irq;
    logic [63:0] v;
    for (int n = 0; n < 2; n++) begin
      bus_write(A_CLEAR, 64'd1);
      bus_write(A_CLEAR, 64'd0);
      bus_write(A_OPER, 64'(n));
      bus_write(A_START, 64'd1);
      bus_read(A_DONE, v);
      total++;
      if (v !== 64'd0) begin bad++; $display("FAIL small%0d_pre: got=%0h want=0", n, v); end
      poll_done(0, 10, cyc, mok, early, irq);
      total++;
      if (cyc != 1) begin bad++; $display("FAIL small%0d_latency: got=%0d want=1", n, cyc); end
      bus_read(A_RESL, v);
      total++;
      if (v !== 64'd1) begin bad++; $display("FAIL small%0d_result_l: got=%0h want=1", n, v); end
      bus_read(A_RESH, v);
      total++;
      if (v !== 64'd0) begin bad++; $display("FAIL small%0d_result_h: got=%0h want=0", n, v); end
    end
  endtask

  task automatic test_clear_priority;
    logic [63:0] v;
    bus_write(A_CLEAR, 64'd1);
    bus_write(A_OPER, 64'd4);
    bus_write(A_START, 64'd1);
    repeat (5) @(posedge clk);
    #1;
    bus_read(A_DONE, v);
    total++;
    if (v !== 64'd0) begin bad++; $display("FAIL prio_opdone: got=%0h want=0", v); end
    bus_read(A_START, v);
    total++;
    if (v !== 64'd0) begin bad++; $display("FAIL prio_opstart: got=%0h want=0", v); end
    bus_write(A_CLEAR, 64'd0);
  endtask

  task automatic test_abort;
    int cyc; bit mok, early; logic irq;
    logic [63:0] v;
    // opclear mid-MULT
    bus_write(A_OPER, 64'd10);
    bus_write(A_START, 64'd1);
    repeat (30) @(posedge clk);
    bus_write(A_CLEAR, 64'd1);
    bus_read(A_DONE, v);
    total++;
    if (v !== 64'd2) begin bad++; $display("FAIL abort_clr_pre: got=%0h want=2", v); end
    @(posedge clk);
    #1;
    bus_read(A_DONE, v);
    total++;
    if (v !== 64'd0) begin bad++; $display("FAIL abort_clr_opdone: got=%0h want=0", v); end
    bus_read(A_RESL, v);
    total++;
    if (v !== 64'd0 || interrupt !== 1'b0) begin bad++; $display("FAIL abort_clr_result: got=%0h irq=%0b want=0/0", v, interrupt); end
    bus_write(A_CLEAR, 64'd0);
    // reset mid-MULT
    bus_write(A_START, 64'd1);
    repeat (30) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    bus_read(A_DONE, v);
    total++;
    if (v !== 64'd0 || interrupt !== 1'b0) begin bad++; $display("FAIL abort_rst_opdone: got=%0h irq=%0b want=0/0", v, interrupt); end
    bus_read(A_RESL, v);
    total++;
    if (v !== 64'd0) begin bad++; $display("FAIL abort_rst_result: got=%0h want=0", v); end
    bus_read(A_OPER, v);
    total++;
    if (v !== 64'd0) begin bad++; $display("FAIL abort_rst_operand: got=%0h want=0", v); end
    @(negedge clk);
    reset_n = 1'b1;
    // fresh run after abort: 3! = 6, no residue of the aborted run
    bus_write(A_OPER, 64'd3);
    bus_write(A_START, 64'd1);
    poll_done(0, 100, cyc, mok, early, irq);
    total++;
    if (cyc != 35) begin bad++; $display("FAIL rerun_latency: got=%0d want=35", cyc); end
    bus_read(A_RESL, v);
    total++;
    if (v !== 64'd6) begin bad++; $display("FAIL rerun_result: got=%0d want=6", v); end
  endtask

  initial begin
    reset_n = 1'b0;
    s_sel = 1'b0; s_wr = 1'b0; s_addr = 16'd0; s_din = 64'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    test_reset;
    test_unmapped;
    test_fact5;
    test_fact10;
    test_fact68_wrap;
    test_small_operands;
    test_clear_priority;
    test_abort;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
